// File: rtl/cv32e40s_instr_obi_responder.sv
// Instruction-side OBI responder with in-order tag/data FIFOs and integrity checking.
// Checks the A-phase checksum of each granted fetch and forwards only the good ones to memory.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   obi_req_i/reqpar_i   A-phase request and its parity (expected !req)
//   obi_addr_i/prot_i/memtype_i/dbg_i/achk_i
//                        fetch attributes and address-phase checksum
//   obi_gnt_o/gntpar_o   grant and its parity
//   obi_rvalid_o/rvalidpar_o/rdata_o/err_o/rchk_o
//                        registered R-phase response and its checksum
//   mem_req_o/addr_o     forwarded memory request (word aligned)
//   mem_rvalid_i/rdata_i/err_i
//                        in-order memory response
//   int_err_o            sticky integrity error flag
module cv32e40s_instr_obi_responder #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        obi_req_i,
    input  logic        obi_reqpar_i,
    input  logic [31:0] obi_addr_i,
    input  logic [2:0]  obi_prot_i,
    input  logic [1:0]  obi_memtype_i,
    input  logic        obi_dbg_i,
    input  logic [11:0] obi_achk_i,
    output logic        obi_gnt_o,
    output logic        obi_gntpar_o,
    output logic        obi_rvalid_o,
    output logic        obi_rvalidpar_o,
    output logic [31:0] obi_rdata_o,
    output logic        obi_err_o,
    output logic [4:0]  obi_rchk_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i,
    output logic        int_err_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);
    localparam logic [PW-1:0] LP_LAST = PW'(DEPTH - 1);

    // Tag FIFO: 1 = LOCAL (checksum failed, answer with error), 0 = FWD.
    logic          r_tag [DEPTH];
    logic [32:0]   r_dat [DEPTH];
    logic [PW-1:0] r_twr, r_trd, r_dwr, r_drd;
    logic [CW-1:0] r_tcnt, r_dcnt;
    // FWD transactions still waiting for their memory response.
    logic [CW-1:0] r_pend;
    logic          r_rvalid;
    logic [31:0]   r_rdata;
    logic          r_err;
    logic          r_int_err;

    logic [11:0]   w_achk_exp;
    logic          w_achk_ok;
    logic          w_gnt;
    logic          w_fwd;
    logic          w_macc;
    logic          w_head_local;
    logic          w_dvalid;
    logic          w_pop;
    logic          w_dpop;
    logic [32:0]   w_dhead;
    logic          w_err_set;
    logic          w_unused;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == LP_LAST) ? '0 : p + PW'(1);
    endfunction

    assign w_achk_exp = {5'b11111,
                         ~^obi_dbg_i,
                         1'b1,
                         ~^{obi_prot_i, obi_memtype_i},
                         ~^obi_addr_i[31:24],
                         ~^obi_addr_i[23:16],
                         ~^obi_addr_i[15:8],
                         ~^{obi_addr_i[7:2], 2'b00}};
    assign w_achk_ok = (obi_achk_i == w_achk_exp);

    // Grant is forced low while reset is asserted.
    assign w_gnt = rst_n & obi_req_i & (r_tcnt < LP_DEPTH);
    assign w_fwd = w_gnt & w_achk_ok;

    // Memory is in order, so an accepted response belongs to the oldest
    // pending FWD entry; unsolicited responses are dropped.
    assign w_macc = mem_rvalid_i & (r_pend != '0);

    // An empty data FIFO is bypassed by an arriving response so it can be
    // returned one cycle after mem_rvalid_i.
    assign w_head_local = r_tag[r_trd];
    assign w_dvalid = (r_dcnt != '0) | w_macc;
    assign w_pop = (r_tcnt != '0) & (w_head_local | w_dvalid);
    assign w_dpop = w_pop & ~w_head_local;
    assign w_dhead = (r_dcnt == '0) ? {mem_rdata_i, mem_err_i} : r_dat[r_drd];

    assign w_err_set = (w_gnt & ~w_achk_ok) |
                       (obi_reqpar_i == obi_req_i) |
                       (mem_rvalid_i & (r_pend == '0));

    assign w_unused = ^obi_addr_i[1:0];

    always_ff @(posedge clk) begin
        if (w_gnt) begin
            r_tag[r_twr] <= ~w_achk_ok;
        end
        if (w_macc) begin
            r_dat[r_dwr] <= {mem_rdata_i, mem_err_i};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_twr     <= '0;
            r_trd     <= '0;
            r_dwr     <= '0;
            r_drd     <= '0;
            r_tcnt    <= '0;
            r_dcnt    <= '0;
            r_pend    <= '0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_int_err <= 1'b0;
        end else begin
            if (w_gnt) begin
                r_twr <= f_inc(r_twr);
            end
            if (w_pop) begin
                r_trd <= f_inc(r_trd);
            end
            if (w_macc) begin
                r_dwr <= f_inc(r_dwr);
            end
            if (w_dpop) begin
                r_drd <= f_inc(r_drd);
            end
            r_tcnt <= r_tcnt + CW'(w_gnt) - CW'(w_pop);
            r_dcnt <= r_dcnt + CW'(w_macc) - CW'(w_dpop);
            r_pend <= r_pend + CW'(w_fwd) - CW'(w_macc);
            r_rvalid <= w_pop;
            if (w_pop && w_head_local) begin
                r_rdata <= '0;
                r_err   <= 1'b1;
            end else if (w_pop) begin
                r_rdata <= w_dhead[32:1];
                r_err   <= w_dhead[0];
            end else begin
                r_rdata <= '0;
                r_err   <= 1'b0;
            end
            if (w_err_set) begin
                r_int_err <= 1'b1;
            end
        end
    end

    assign obi_gnt_o       = w_gnt;
    assign obi_gntpar_o    = ~w_gnt;
    assign obi_rvalid_o    = r_rvalid;
    assign obi_rvalidpar_o = ~r_rvalid;
    assign obi_rdata_o     = r_rdata;
    assign obi_err_o       = r_err;
    assign obi_rchk_o      = {~^{r_err, 1'b0},
                              ~^r_rdata[31:24],
                              ~^r_rdata[23:16],
                              ~^r_rdata[15:8],
                              ~^r_rdata[7:0]};
    assign mem_req_o       = w_fwd;
    assign mem_addr_o      = {obi_addr_i[31:2], 2'b00};
    assign int_err_o       = r_int_err;

endmodule

// File: tb/tb_cv32e40s_instr_obi_responder.sv
// Self-checking bench for cv32e40s_instr_obi_responder.
// Vector table, directed corner sequences and a random run against a queue-based model.
module tb_cv32e40s_instr_obi_responder;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst_n;
    logic        obi_req_i;
    logic        obi_reqpar_i;
    logic [31:0] obi_addr_i;
    logic [2:0]  obi_prot_i;
    logic [1:0]  obi_memtype_i;
    logic        obi_dbg_i;
    logic [11:0] obi_achk_i;
    logic        obi_gnt_o;
    logic        obi_gntpar_o;
    logic        obi_rvalid_o;
    logic        obi_rvalidpar_o;
    logic [31:0] obi_rdata_o;
    logic        obi_err_o;
    logic [4:0]  obi_rchk_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        mem_err_i;
    logic        int_err_o;

    cv32e40s_instr_obi_responder #(.DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .obi_req_i       (obi_req_i),
        .obi_reqpar_i    (obi_reqpar_i),
        .obi_addr_i      (obi_addr_i),
        .obi_prot_i      (obi_prot_i),
        .obi_memtype_i   (obi_memtype_i),
        .obi_dbg_i       (obi_dbg_i),
        .obi_achk_i      (obi_achk_i),
        .obi_gnt_o       (obi_gnt_o),
        .obi_gntpar_o    (obi_gntpar_o),
        .obi_rvalid_o    (obi_rvalid_o),
        .obi_rvalidpar_o (obi_rvalidpar_o),
        .obi_rdata_o     (obi_rdata_o),
        .obi_err_o       (obi_err_o),
        .obi_rchk_o      (obi_rchk_o),
        .mem_req_o       (mem_req_o),
        .mem_addr_o      (mem_addr_o),
        .mem_rvalid_i    (mem_rvalid_i),
        .mem_rdata_i     (mem_rdata_i),
        .mem_err_i       (mem_err_i),
        .int_err_o       (int_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          loc;
        bit          hasd;
        logic [31:0] d;
        bit          e;
    } ent_t;

    typedef struct {
        int          t;
        logic [31:0] d;
        bit          e;
    } mrsp_t;

    ent_t        tq[$];
    mrsp_t       mq[$];
    logic [32:0] obs[$];
    int          cyc = 0;
    int          last_t = 0;
    bit          m_rv;
    logic [31:0] m_rd;
    bit          m_er;
    bit          m_ie;
    int          n_dgnt;
    int          n_dmreq;

    function automatic logic [11:0] achk_of(input logic [31:0] a, input logic [2:0] p,
                                            input logic [1:0] m, input logic d);
        logic [11:0] r;
        r[11:7] = 5'b11111;
        r[6] = ~^d;
        r[5] = 1'b1;
        r[4] = ~^{p, m};
        r[3] = ~^a[31:24];
        r[2] = ~^a[23:16];
        r[1] = ~^a[15:8];
        r[0] = ~^{a[7:2], 2'b00};
        return r;
    endfunction

    function automatic logic [4:0] rchk_of(input logic [31:0] d, input logic e);
        return {~e, ~^d[31:24], ~^d[23:16], ~^d[15:8], ~^d[7:0]};
    endfunction

    // Memory contents seen by the bench: {rdata, err}.
    function automatic logic [32:0] mem_of(input logic [31:0] a);
        if (a[31:2] == 30'h400) return {32'h1234_5678, 1'b0};
        return {a ^ 32'hC3A5_5A3C, a[3] & a[6]};
    endfunction

    task automatic chk_rst(input string tag);
        chk({tag, "_gnt"}, obi_gnt_o, 0);
        chk({tag, "_gntpar"}, obi_gntpar_o, 1);
        chk({tag, "_rvalid"}, obi_rvalid_o, 0);
        chk({tag, "_rvalidpar"}, obi_rvalidpar_o, 1);
        chk({tag, "_rdata"}, obi_rdata_o, 0);
        chk({tag, "_err"}, obi_err_o, 0);
        chk({tag, "_rchk"}, obi_rchk_o, 5'b11111);
        chk({tag, "_memreq"}, mem_req_o, 0);
        chk({tag, "_interr"}, int_err_o, 0);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        obi_req_i = 1'b1;
        obi_reqpar_i = 1'b0;
        obi_addr_i = 32'h1000;
        obi_achk_i = achk_of(32'h1000, 3'd0, 2'd0, 1'b0);
        mem_rvalid_i = 1'b0;
        #1;
        chk_rst(tag);
        tq.delete();
        mq.delete();
        m_rv = 0;
        m_rd = '0;
        m_er = 0;
        m_ie = 0;
        last_t = cyc;
        repeat (2) @(negedge clk);
        obi_req_i = 1'b0;
        obi_reqpar_i = 1'b1;
        rst_n = 1'b1;
    endtask

    task automatic step(input bit req, input logic [31:0] addr, input logic [2:0] prot,
                        input logic [1:0] mt, input bit dbg, input bit bad,
                        input bit parbad, input bit spur, input int lat);
        bit          e_gnt;
        bit          e_mreq;
        int          idx;
        int          t;
        logic [32:0] md;
        ent_t        x;
        @(negedge clk);
        obi_req_i = req;
        obi_reqpar_i = parbad ? req : ~req;
        obi_addr_i = addr;
        obi_prot_i = prot;
        obi_memtype_i = mt;
        obi_dbg_i = dbg;
        obi_achk_i = achk_of(addr, prot, mt, dbg) ^ (bad ? 12'h001 : 12'h000);
        if (mq.size() > 0 && mq[0].t == cyc) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i = mq[0].d;
            mem_err_i = mq[0].e;
        end else begin
            mem_rvalid_i = spur;
            mem_rdata_i = $urandom;
            mem_err_i = 1'($urandom_range(0, 1));
        end
        #1;
        e_gnt = req && (tq.size() < DEPTH);
        e_mreq = e_gnt && !bad;
        chk("gnt", obi_gnt_o, e_gnt);
        chk("gntpar", obi_gntpar_o, !e_gnt);
        chk("mem_req", mem_req_o, e_mreq);
        if (e_mreq) chk("mem_addr", mem_addr_o, {addr[31:2], 2'b00});
        chk("rvalid", obi_rvalid_o, m_rv);
        chk("rvalidpar", obi_rvalidpar_o, !m_rv);
        chk("rdata", obi_rdata_o, m_rd);
        chk("err", obi_err_o, m_er);
        chk("rchk", obi_rchk_o, rchk_of(m_rd, m_er));
        chk("int_err", int_err_o, m_ie);
        if (obi_gnt_o) n_dgnt++;
        if (mem_req_o) n_dmreq++;
        if (obi_rvalid_o) obs.push_back({obi_rdata_o, obi_err_o});
        // Model: attach data, pop oldest complete response, then accept new fetch.
        if (mem_rvalid_i) begin
            idx = -1;
            for (int i = 0; i < tq.size(); i++)
                if (idx < 0 && !tq[i].loc && !tq[i].hasd) idx = i;
            if (idx >= 0) begin
                x = tq[idx];
                x.hasd = 1;
                x.d = mem_rdata_i;
                x.e = mem_err_i;
                tq[idx] = x;
            end else begin
                m_ie = 1;
            end
            if (mq.size() > 0 && mq[0].t == cyc) void'(mq.pop_front());
        end
        if (tq.size() > 0 && (tq[0].loc || tq[0].hasd)) begin
            m_rv = 1;
            m_rd = tq[0].loc ? 32'h0 : tq[0].d;
            m_er = tq[0].loc ? 1'b1 : tq[0].e;
            void'(tq.pop_front());
        end else begin
            m_rv = 0;
            m_rd = '0;
            m_er = 0;
        end
        if (e_gnt) begin
            tq.push_back('{bad, 1'b0, 32'h0, 1'b0});
            if (bad) m_ie = 1;
        end
        if (e_mreq) begin
            md = mem_of(addr);
            t = cyc + lat;
            if (t <= last_t) t = last_t + 1;
            last_t = t;
            mq.push_back('{t, md[32:1], md[0]});
        end
        if (parbad) m_ie = 1;
        cyc++;
    endtask

    task automatic fetch(input logic [31:0] a, input bit bad, input int lat);
        step(1'b1, a, 3'd0, 2'd0, 1'b0, bad, 1'b0, 1'b0, lat);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, $urandom, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    endtask

    typedef struct {
        bit          req;
        bit          par;
        logic [31:0] addr;
        logic [2:0]  prot;
        logic [1:0]  mt;
        bit          dbg;
        logic [11:0] achk;
        bit          gnt;
        bit          mreq;
        logic [31:0] maddr;
        bit          ie;
    } vec_t;

    vec_t        vt[8];
    logic [32:0] ma;

    initial begin
        rst_n = 1'b0;
        obi_req_i = 1'b0;
        obi_reqpar_i = 1'b1;
        obi_addr_i = '0;
        obi_prot_i = '0;
        obi_memtype_i = '0;
        obi_dbg_i = 1'b0;
        obi_achk_i = '0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i = '0;
        mem_err_i = 1'b0;

        vt[0] = '{1'b1, 1'b0, 32'h0000_1000, 3'd0, 2'd0, 1'b0, 12'hFFD, 1'b1, 1'b1, 32'h0000_1000, 1'b0};
        vt[1] = '{1'b1, 1'b0, 32'h0000_1000, 3'd0, 2'd0, 1'b0, 12'hFFC, 1'b1, 1'b0, 32'h0, 1'b1};
        vt[2] = '{1'b0, 1'b0, 32'h0000_1000, 3'd0, 2'd0, 1'b0, 12'hFFD, 1'b0, 1'b0, 32'h0, 1'b1};
        vt[3] = '{1'b0, 1'b1, 32'h0000_1000, 3'd0, 2'd0, 1'b0, 12'hFFD, 1'b0, 1'b0, 32'h0, 1'b0};
        vt[4] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 3'd7, 2'd3, 1'b1, 12'hFAF, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0};
        vt[5] = '{1'b1, 1'b0, 32'h8000_0007, 3'd1, 2'd0, 1'b0, 12'hFE6, 1'b1, 1'b1, 32'h8000_0004, 1'b0};
        vt[6] = '{1'b1, 1'b0, 32'h0000_1000, 3'd0, 2'd0, 1'b0, 12'h7FD, 1'b1, 1'b0, 32'h0, 1'b1};
        vt[7] = '{1'b1, 1'b1, 32'h0000_1000, 3'd0, 2'd0, 1'b0, 12'hFFD, 1'b1, 1'b1, 32'h0000_1000, 1'b1};

        do_reset("por");

        for (int i = 0; i < 8; i++) begin
            do_reset($sformatf("v%0d_rst", i));
            @(negedge clk);
            obi_req_i = vt[i].req;
            obi_reqpar_i = vt[i].par;
            obi_addr_i = vt[i].addr;
            obi_prot_i = vt[i].prot;
            obi_memtype_i = vt[i].mt;
            obi_dbg_i = vt[i].dbg;
            obi_achk_i = vt[i].achk;
            #1;
            chk($sformatf("v%0d_gnt", i), obi_gnt_o, vt[i].gnt);
            chk($sformatf("v%0d_gntpar", i), obi_gntpar_o, !vt[i].gnt);
            chk($sformatf("v%0d_memreq", i), mem_req_o, vt[i].mreq);
            if (vt[i].mreq) chk($sformatf("v%0d_maddr", i), mem_addr_o, vt[i].maddr);
            @(negedge clk);
            obi_req_i = 1'b0;
            obi_reqpar_i = 1'b1;
            #1;
            chk($sformatf("v%0d_interr", i), int_err_o, vt[i].ie);
        end

        // Single fetch, memory answers two cycles after the grant.
        do_reset("s1_rst");
        fetch(32'h0000_1000, 1'b0, 2);
        chk("s1_memreq", mem_req_o, 1);
        chk("s1_maddr", mem_addr_o, 32'h0000_1000);
        idle(1);
        idle(1);
        chk("s1_mrvalid_cycle_rv", obi_rvalid_o, 0);
        idle(1);
        chk("s1_rvalid", obi_rvalid_o, 1);
        chk("s1_rdata", obi_rdata_o, 32'h1234_5678);
        chk("s1_err", obi_err_o, 0);
        chk("s1_rchk", obi_rchk_o, 5'b11011);
        idle(1);
        chk("s1_rvalid_end", obi_rvalid_o, 0);
        chk("s1_rdata_end", obi_rdata_o, 0);

        // Back-pressure with request held and memory latency 5.
        do_reset("s2_rst");
        n_dgnt = 0;
        for (int i = 0; i < 6; i++) fetch(32'h2000 + 32'(4 * i), 1'b0, 5);
        chk("s2_grants_before_pop", n_dgnt, 2);
        fetch(32'h2100, 1'b0, 5);
        chk("s2_third_grant", n_dgnt, 3);
        idle(12);

        // Good fetch with late data followed by a bad-checksum fetch.
        do_reset("s3_rst");
        obs.delete();
        n_dmreq = 0;
        fetch(32'h0000_3000, 1'b0, 6);
        fetch(32'h0000_3004, 1'b1, 1);
        idle(10);
        ma = mem_of(32'h0000_3000);
        chk("s3_resp_count", obs.size(), 2);
        if (obs.size() >= 2) begin
            chk("s3_first", obs[0], ma);
            chk("s3_second", obs[1], {32'h0, 1'b1});
        end
        chk("s3_mem_reqs", n_dmreq, 1);
        chk("s3_interr", int_err_o, 1);

        // Request parity error while idle is sticky.
        do_reset("s4_rst");
        n_dgnt = 0;
        step(1'b0, 32'h0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        idle(4);
        chk("s4_interr_sticky", int_err_o, 1);
        chk("s4_no_grant", n_dgnt, 0);

        // Unsolicited memory response.
        do_reset("s5_rst");
        step(1'b0, 32'h0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        idle(2);
        chk("s5_interr", int_err_o, 1);
        chk("s5_no_rvalid", obi_rvalid_o, 0);

        // Asynchronous reset with two fetches outstanding.
        do_reset("s6_pre");
        fetch(32'h0000_6000, 1'b0, 8);
        fetch(32'h0000_6004, 1'b0, 8);
        idle(1);
        #2;
        do_reset("s6_async");
        n_dgnt = 0;
        fetch(32'h0000_1000, 1'b0, 2);
        chk("s6_grant_after_rst", n_dgnt, 1);
        idle(6);

        // Random traffic against the model.
        do_reset("rnd_rst");
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 9) < 7), $urandom, 3'($urandom), 2'($urandom),
                 1'($urandom), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 63) == 0), 1'b0, $urandom_range(1, 6));
        end
        idle(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
